// File: rtl/clkdiv_pkg.sv
// Board constants and helpers shared by the programmable clock divider.
// hz_to_half converts a target frequency into the half-period register value.
package clkdiv_pkg;

  function automatic int unsigned hz_to_half(input int unsigned clk_hz, input int unsigned f);
    return clk_hz / (2 * f) - 1;
  endfunction

  localparam int unsigned CLK_HZ     = 100_000_000;
  localparam int unsigned HALF_1HZ   = hz_to_half(CLK_HZ, 1);
  localparam int unsigned HALF_100HZ = hz_to_half(CLK_HZ, 100);

endpackage

// File: rtl/div_channel.sv
// One divider channel: half-period register, counter, and registered square wave / tick.
// The terminal compare is >= so that lowering the half-period mid-count never waits for a wrap.
module div_channel #(
  parameter int               CNT_W    = 26,
  parameter logic [CNT_W-1:0] RST_HALF = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             sync_clr_i,
  input  logic             cfg_we_i,
  input  logic [CNT_W-1:0] cfg_half_i,
  output logic             clk_o,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q;
    clk_d  = clk_q;
    tick_d = 1'b0;
    half_d = cfg_we_i ? cfg_half_i : half_q;
    if (sync_clr_i) begin
      cnt_d = '0;
      clk_d = 1'b0;
    end else if (en_i) begin
      if (cnt_q >= half_q) begin
        cnt_d  = '0;
        clk_d  = ~clk_q;
        tick_d = ~clk_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      half_q <= RST_HALF;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      half_q <= half_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clk_o  = clk_q;
  assign tick_o = tick_q;

endmodule

// File: rtl/programmable_clock_divider.sv
// Multi-channel programmable clock divider with per-channel runtime half-period and
// a free-running scan counter for seven-segment digit selection.
module programmable_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int                      NUM_CH   = 2,
  parameter int                      CNT_W    = 26,
  parameter logic [NUM_CH*CNT_W-1:0] DEF_HALF = {CNT_W'(HALF_100HZ), CNT_W'(HALF_1HZ)},
  parameter int                      SCAN_W   = 2,
  parameter int                      SCAN_LSB = 16,
  localparam int                     CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync_clr,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [SCAN_W-1:0] scan
);

  localparam int SC_W = SCAN_LSB + SCAN_W;

  logic [SC_W-1:0] scan_q, scan_d;

  assign scan_d = scan_q + SC_W'(1);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) scan_q <= '0;
    else     scan_q <= scan_d;
  end

  assign scan = scan_q[SCAN_LSB +: SCAN_W];

  // Out-of-range cfg_ch values match no channel, so such writes fall away naturally.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [CH_W-1:0] IDX = CH_W'(i);
    logic we;
    assign we = cfg_we && (cfg_ch == IDX);

    div_channel #(
      .CNT_W    (CNT_W),
      .RST_HALF (DEF_HALF[i*CNT_W +: CNT_W])
    ) u_ch (
      .clk_i      (clk_in),
      .rst_i      (rst),
      .en_i       (en[i]),
      .sync_clr_i (sync_clr),
      .cfg_we_i   (we),
      .cfg_half_i (cfg_half),
      .clk_o      (clk_out[i]),
      .tick_o     (tick[i])
    );
  end

endmodule

// File: tb/tb_programmable_clock_divider.sv
// Directed bench for programmable_clock_divider: three channels with reset half-periods
// {0,1,3}, scan taken from the counter LSBs so it counts 0,1,2,3.
module tb_programmable_clock_divider;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 8;

  logic              clk_in   = 1'b0;
  logic              rst      = 1'b1;
  logic [NUM_CH-1:0] en       = '1;
  logic              sync_clr = 1'b0;
  logic              cfg_we   = 1'b0;
  logic [1:0]        cfg_ch   = '0;
  logic [CNT_W-1:0]  cfg_half = '0;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic [1:0]        scan;

  int n_tests = 0;
  int n_fail  = 0;

  // After reset release, edge k = 1..16
  logic [1:16] e0c = 16'b0001111000011110, e0t = 16'b0001000000010000;
  logic [1:16] e1c = 16'b0110011001100110, e1t = 16'b0100010001000100;
  logic [1:16] e2c = 16'b1010101010101010, e2t = 16'b1010101010101010;
  // Ch0 after the 5 -> 1 reprogram, edges 20..24
  logic [20:24] rpc = 5'b11001, rpt = 5'b10001;
  // After sync_clr, en[1] low for j = 5..9
  logic [1:14] g0c = 14'b01100110011001, g0t = 14'b01000100010001;
  logic [1:14] g1c = 14'b00111111110001, g1t = 14'b00100000000001;
  logic [1:14] g2c = 14'b10101010101010, g2t = 14'b10101010101010;
  // After sync_clr with an out-of-range write
  logic [1:6] o0c = 6'b011001, o1c = 6'b001110, o2c = 6'b101010;

  always #5 clk_in = ~clk_in;

  programmable_clock_divider #(
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W),
    .DEF_HALF ({8'd0, 8'd1, 8'd3}),
    .SCAN_W   (2),
    .SCAN_LSB (0)
  ) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .en       (en),
    .sync_clr (sync_clr),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_half (cfg_half),
    .clk_out  (clk_out),
    .tick     (tick),
    .scan     (scan)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic reset_run(input string tag, input int n);
    for (int k = 1; k <= n; k++) begin
      step();
      chk($sformatf("%s_clk%0d", tag, k), clk_out, {e2c[k], e1c[k], e0c[k]});
      chk($sformatf("%s_tick%0d", tag, k), tick, {e2t[k], e1t[k], e0t[k]});
      chk($sformatf("%s_scan%0d", tag, k), scan, k % 4);
    end
  endtask

  initial begin
    #2;
    chk("rst_clk", clk_out, 0);
    chk("rst_tick", tick, 0);
    chk("rst_scan", scan, 0);
    @(negedge clk_in);
    rst = 1'b0;
    reset_run("boot", 16);

    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd5;
    step();
    cfg_we = 1'b0;
    step();
    cfg_we = 1'b1; cfg_half = 8'd1;
    step();
    cfg_we = 1'b0;
    chk("reprog_pre_clk0", clk_out[0], 0);
    for (int k = 20; k <= 24; k++) begin
      step();
      chk($sformatf("reprog_clk0_e%0d", k), clk_out[0], rpc[k]);
      chk($sformatf("reprog_tick0_e%0d", k), tick[0], rpt[k]);
    end

    sync_clr = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd1; cfg_half = 8'd2;
    step();
    sync_clr = 1'b0; cfg_we = 1'b0;
    chk("sclr_clk", clk_out, 0);
    chk("sclr_tick", tick, 0);
    chk("sclr_scan", scan, 1);
    for (int j = 1; j <= 14; j++) begin
      en[1] = !(j >= 5 && j <= 9);
      step();
      chk($sformatf("gate_clk%0d", j), clk_out, {g2c[j], g1c[j], g0c[j]});
      chk($sformatf("gate_tick%0d", j), tick, {g2t[j], g1t[j], g0t[j]});
    end
    chk("gate_scan", scan, 3);

    en = '1;
    sync_clr = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd3; cfg_half = 8'd0;
    step();
    sync_clr = 1'b0; cfg_we = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      step();
      chk($sformatf("oor_clk%0d", j), clk_out, {o2c[j], o1c[j], o0c[j]});
    end

    @(posedge clk_in);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_clk", clk_out, 0);
    chk("arst_tick", tick, 0);
    chk("arst_scan", scan, 0);
    @(negedge clk_in);
    rst = 1'b0;
    reset_run("rerst", 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
